pulse_count_crossing: RTL and testbench

Lossless event-count transfer from the `clk_in` domain to the `clock_out` domain. Every `pulse_in` is accumulated in a source-side counter. Batched counts cross through a 4-phase req/ack handshake with the data bus held stable, so pulses arriving while a transfer is in flight are counted rather than dropped. The block sits beside the single-pulse DDR-done crossing, on paths where every event must reach the slow domain, such as DDR write-done and event-ready counts.

---
 rtl/pulse_xing_pkg.sv | 16 +
 rtl/pulse_count_crossing_sync_bits.sv | 28 ++
 rtl/pulse_count_crossing.sv | 137 +++++++++++++
 tb/tb_pulse_count_crossing.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_xing_pkg.sv
// pulse_xing_pkg: shared types and defaults for the pulse-count crossing.
//   src_state_t      - source-side handshake FSM states
//   SYNC_STAGES_DEF  - default synchronizer depth (legal 2..4)
//   CNT_W_DEF        - default accumulator / count width
package pulse_xing_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } src_state_t;

endpackage

// File: rtl/pulse_count_crossing_sync_bits.sv
// sync_bits: multi-flop synchronizer chain with asynchronous clear.
//   clk    in  destination clock of the chain
//   rst_n  in  asynchronous active-low clear of every stage
//   d      in  W-bit asynchronous input
//   q      out W-bit synchronized output (last stage)
// STAGES must be at least 2.
module sync_bits
  import pulse_xing_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pulse_count_crossing.sv
// pulse_count_crossing: lossless event-count transfer from clk_in to clock_out.
// Pulses accumulate in a saturating source counter; batches are moved into a
// hold register and handed across with a 4-phase req/ack handshake while hold
// stays frozen, so nothing arriving mid-transfer is dropped.
//
// Ports:
//   clk_in      in   source clock
//   resetn_in   in   source reset, async active-low
//   clock_out   in   destination clock
//   resetn_out  in   destination reset, async active-low
//   pulse_in    in   event strobe (clk_in), one event per high cycle
//   busy_in     out  clk_in: source FSM not IDLE
//   ovf_in      out  clk_in: sticky accumulator saturation flag
//   cnt_out     out  clock_out: count delivered by the last transfer
//   cnt_valid   out  clock_out: one-cycle strobe qualifying cnt_out
//
// Configuration macro PULSE_COUNT_XING_OVF_EN: when defined, ovf_in latches
// on a dropped pulse until resetn_in; when undefined ovf_in is tied low.
// SYNC_STAGES legal range is 2..4.
module pulse_count_crossing
  import pulse_xing_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk_in,
  input  logic             resetn_in,
  input  logic             clock_out,
  input  logic             resetn_out,
  input  logic             pulse_in,
  output logic             busy_in,
  output logic             ovf_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid
);

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  // ---------------- source domain ----------------
  src_state_t       state, state_nxt;
  logic [CNT_W-1:0] acc, hold;
  logic             req, ack, ack_sync;
  logic             load, acc_max;

  assign acc_max = (acc == ACC_MAX);

  // A new request also waits for ack_sync low so a stale ack left over from a
  // source reset cannot be mistaken for the ack of the next transfer.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if ((acc != '0) && !ack_sync) begin
          load      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ:     if (ack_sync)  state_nxt = ACK_LOW;
      ACK_LOW: if (!ack_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) state <= IDLE;
    else            state <= state_nxt;
  end

  // On the load cycle acc restarts at pulse_in so a coincident pulse survives.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      acc  <= '0;
      hold <= '0;
      req  <= 1'b0;
    end else begin
      if (load) begin
        hold <= acc;
        acc  <= CNT_W'(pulse_in);
      end else if (pulse_in && !acc_max) begin
        acc  <= acc + 1'b1;
      end

      if (load)                        req <= 1'b1;
      else if (state == REQ && ack_sync) req <= 1'b0;
    end
  end

  assign busy_in = (state != IDLE);

`ifdef PULSE_COUNT_XING_OVF_EN
  // Flags only pulses that are actually lost: on the load cycle acc restarts
  // from pulse_in, so a pulse there is counted even if acc was at max.
  logic ovf_q;
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in)                          ovf_q <= 1'b0;
    else if (pulse_in && acc_max && !load)   ovf_q <= 1'b1;
  end
  assign ovf_in = ovf_q;
`else
  assign ovf_in = 1'b0;
`endif

  sync_bits #(.STAGES(SYNC_STAGES), .W(1)) u_ack_sync (
    .clk   (clk_in),
    .rst_n (resetn_in),
    .d     (ack),
    .q     (ack_sync)
  );

  // ---------------- destination domain ----------------
  logic req_sync, req_d;

  sync_bits #(.STAGES(SYNC_STAGES), .W(1)) u_req_sync (
    .clk   (clock_out),
    .rst_n (resetn_out),
    .d     (req),
    .q     (req_sync)
  );

  // hold is only sampled between req rising and ack returning, when the
  // source guarantees it is stable.
  always_ff @(posedge clock_out or negedge resetn_out) begin
    if (!resetn_out) begin
      req_d     <= 1'b0;
      ack       <= 1'b0;
      cnt_valid <= 1'b0;
      cnt_out   <= '0;
    end else begin
      req_d     <= req_sync;
      ack       <= req_sync;
      cnt_valid <= req_sync && !req_d;
      if (req_sync && !req_d) cnt_out <= hold;
    end
  end

endmodule

// File: tb/tb_pulse_count_crossing.sv
// Bench for pulse_count_crossing: a CNT_W=16 instance for functional tests and a
// CNT_W=4 instance with a gateable destination clock for saturation.
module tb_pulse_count_crossing;

  localparam int CW = 16;
`ifdef PULSE_COUNT_XING_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic clk_in = 1'b0, clock_out = 1'b0;
  logic resetn_in = 1'b0, resetn_out = 1'b0, pulse_in = 1'b0;
  logic busy_in, ovf_in, cnt_valid;
  logic [CW-1:0] cnt_out;

  logic cob_en = 1'b0, rb_in = 1'b0, rb_out = 1'b0, pulse_b = 1'b0;
  logic busy_b, ovf_b, valid_b, clock_out_b;
  logic [3:0] cnt_b;

  int half_in = 5, half_out = 20;
  always #(half_in)  clk_in    = ~clk_in;
  always #(half_out) clock_out = ~clock_out;
  assign clock_out_b = clock_out & cob_en;

  pulse_count_crossing #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .resetn_in(resetn_in), .clock_out(clock_out), .resetn_out(resetn_out),
    .pulse_in(pulse_in), .busy_in(busy_in), .ovf_in(ovf_in), .cnt_out(cnt_out), .cnt_valid(cnt_valid)
  );

  pulse_count_crossing #(.CNT_W(4), .SYNC_STAGES(2)) dut_sat (
    .clk_in(clk_in), .resetn_in(rb_in), .clock_out(clock_out_b), .resetn_out(rb_out),
    .pulse_in(pulse_b), .busy_in(busy_b), .ovf_in(ovf_b), .cnt_out(cnt_b), .cnt_valid(valid_b)
  );

  int checks = 0, passes = 0;
  int unsigned exp_q[$], obs_q[$], obs_b_q[$];
  int unsigned delivered = 0;

  // Strobe monitors: cnt_valid spans one destination cycle, sample mid-cycle.
  always @(negedge clock_out) if (cnt_valid) begin
    obs_q.push_back(int'(cnt_out));
    delivered += int'(cnt_out);
  end
  always @(negedge clock_out_b) if (valid_b) obs_b_q.push_back(int'(cnt_b));

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  task automatic pulse_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in); pulse_in = 1'b1;
    end
    @(negedge clk_in); pulse_in = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin @(posedge clk_in); k++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k;
    k = 0;
    while (busy_in && k < budget) begin @(posedge clk_in); k++; end
    #1 ok = !busy_in;
  endtask

  // Wait for cnt_valid at a clock_out edge; returns just after that edge.
  task automatic wait_strobe_edge(input int budget, output bit ok, output int unsigned val);
    int k;
    k = 0; ok = 1'b0; val = 0;
    while (!ok && k < budget) begin
      @(posedge clock_out); #1;
      if (cnt_valid) begin ok = 1'b1; val = int'(cnt_out); end
      k++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (busy_in !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_in); else passes++;
    checks++; if (ovf_in !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_in); else passes++;
    checks++; if (cnt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cnt_valid); else passes++;
    checks++; if (cnt_out !== '0) $display("FAIL reset_cnt: got %0d want 0", cnt_out); else passes++;
    @(negedge clk_in); resetn_in = 1'b1; resetn_out = 1'b1;
    repeat (5) @(posedge clk_in);
  endtask

  task automatic test_single;
    bit ok; int unsigned e, g;
    pulse_n(1); exp_q.push_back(1);
    wait_obs(1, 300, ok);
    checks++; if (!ok) $display("FAIL single_strobe: strobes %0d want 1", obs_q.size()); else passes++;
    e = exp_q.pop_front(); g = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFF_FFFF;
    checks++; if (g !== e) $display("FAIL single_cnt: got %0d want %0d", g, e); else passes++;
    wait_idle(300, ok);
    checks++; if (!ok) $display("FAIL single_idle: busy_in=%b want 0", busy_in); else passes++;
    repeat (60) @(posedge clk_in);
    checks++; if (obs_q.size() != 0) $display("FAIL single_extra: extra strobes %0d want 0", obs_q.size()); else passes++;
  endtask

  task automatic test_back_to_back;
    bit ok; int unsigned e, g, tot;
    half_in = 5; half_out = 20; tot = 0;
    repeat (4) @(posedge clock_out);
    pulse_n(5); exp_q.push_back(1); exp_q.push_back(4);
    wait_obs(2, 600, ok);
    checks++; if (!ok) $display("FAIL b2b_strobes: strobes %0d want 2", obs_q.size()); else passes++;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); g = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFF_FFFF;
      tot += g;
      checks++; if (g !== e) $display("FAIL b2b_cnt%0d: got %0d want %0d", i, g, e); else passes++;
    end
    checks++; if (tot != 5) $display("FAIL b2b_total: got %0d want 5", tot); else passes++;
    wait_idle(300, ok);
    repeat (40) @(posedge clk_in);
    obs_q.delete();
  endtask

  task automatic test_random;
    int hi[3] = '{5, 5, 13};
    int ho[3] = '{20, 7, 5};
    int unsigned driven, e;
    for (int r = 0; r < 3; r++) begin
      half_in = hi[r]; half_out = ho[r];
      repeat (4) @(posedge clock_out);
      @(negedge clk_in);
      driven = 0; delivered = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk_in);
        pulse_in = 1'($urandom_range(0, 1));
        driven += pulse_in;
      end
      @(negedge clk_in); pulse_in = 1'b0;
      exp_q.push_back(driven);
      repeat (400) @(posedge clk_in);
      e = exp_q.pop_front();
      checks++;
      if (delivered !== e) $display("FAIL random_sum r%0d: delivered %0d want %0d", r, delivered, e);
      else passes++;
      obs_q.delete();
    end
    half_in = 5; half_out = 20;
    repeat (10) @(posedge clk_in);
  endtask

  task automatic test_src_reset;
    bit ok; int unsigned v, e, g;
    pulse_n(1); exp_q.push_back(1);
    wait_strobe_edge(50, ok, v);
    checks++; if (!ok) $display("FAIL srcrst_first: no strobe seen"); else passes++;
    checks++; if (busy_in !== 1'b1) $display("FAIL srcrst_inreq: busy_in=%b want 1", busy_in); else passes++;
    resetn_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    checks++; if (busy_in !== 1'b0) $display("FAIL srcrst_busy: busy_in=%b want 0", busy_in); else passes++;
    @(negedge clk_in); resetn_in = 1'b1;
    repeat (80) @(posedge clk_in);
    checks++; if (obs_q.size() != 1) $display("FAIL srcrst_once: strobes %0d want 1", obs_q.size()); else passes++;
    e = exp_q.pop_front(); g = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFF_FFFF;
    checks++; if (g !== e) $display("FAIL srcrst_cnt: got %0d want %0d", g, e); else passes++;
    obs_q.delete();
    pulse_n(1); exp_q.push_back(1);
    wait_obs(1, 300, ok);
    e = exp_q.pop_front(); g = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFF_FFFF;
    checks++; if (g !== e) $display("FAIL srcrst_next: got %0d want %0d", g, e); else passes++;
    wait_idle(300, ok);
    repeat (40) @(posedge clk_in);
    obs_q.delete();
  endtask

  task automatic test_dst_reset;
    bit ok; int unsigned v, e, g;
    pulse_n(1); exp_q.push_back(1); exp_q.push_back(1);
    wait_strobe_edge(50, ok, v);
    resetn_out = 1'b0;
    e = exp_q.pop_front();
    checks++; if (!ok || v !== e) $display("FAIL dstrst_first: got %0d (seen %b) want %0d", v, ok, e); else passes++;
    checks++; if (busy_in !== 1'b1) $display("FAIL dstrst_inreq: busy_in=%b want 1", busy_in); else passes++;
    repeat (10) @(posedge clock_out);
    #1;
    checks++; if (cnt_valid !== 1'b0 || obs_q.size() != 0)
      $display("FAIL dstrst_quiet: valid=%b strobes=%0d want 0/0", cnt_valid, obs_q.size());
    else passes++;
    @(negedge clock_out); resetn_out = 1'b1;
    wait_obs(1, 300, ok);
    e = exp_q.pop_front(); g = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFF_FFFF;
    checks++; if (g !== e) $display("FAIL dstrst_redeliver: got %0d want %0d", g, e); else passes++;
    wait_idle(300, ok);
    checks++; if (!ok) $display("FAIL dstrst_idle: busy_in=%b want 0", busy_in); else passes++;
    repeat (40) @(posedge clk_in);
    checks++; if (obs_q.size() != 0) $display("FAIL dstrst_extra: strobes %0d want 0", obs_q.size()); else passes++;
  endtask

  task automatic test_saturation;
    int k; int unsigned e, g;
    @(negedge clk_in); rb_in = 1'b1; rb_out = 1'b1;
    repeat (3) @(posedge clk_in);
    for (int i = 0; i < 20; i++) begin @(negedge clk_in); pulse_b = 1'b1; end
    @(negedge clk_in); pulse_b = 1'b0;
    exp_q.push_back(1); exp_q.push_back(15);
    repeat (10) @(posedge clk_in);
    #1;
    checks++; if (busy_b !== 1'b1) $display("FAIL sat_busy: got %b want 1", busy_b); else passes++;
    checks++; if (ovf_b !== EXP_OVF) $display("FAIL sat_ovf: got %b want %b", ovf_b, EXP_OVF); else passes++;
    checks++; if (obs_b_q.size() != 0) $display("FAIL sat_stopped: strobes %0d want 0", obs_b_q.size()); else passes++;
    @(negedge clock_out); cob_en = 1'b1;
    k = 0;
    while (obs_b_q.size() < 2 && k < 600) begin @(posedge clk_in); k++; end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); g = (obs_b_q.size() > 0) ? obs_b_q.pop_front() : 32'hFFFF_FFFF;
      checks++; if (g !== e) $display("FAIL sat_cnt%0d: got %0d want %0d", i, g, e); else passes++;
    end
    k = 0;
    while (busy_b && k < 300) begin @(posedge clk_in); k++; end
    #1;
    checks++; if (busy_b !== 1'b0) $display("FAIL sat_idle: got %b want 0", busy_b); else passes++;
    checks++; if (ovf_b !== EXP_OVF) $display("FAIL sat_ovf_sticky: got %b want %b", ovf_b, EXP_OVF); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_src_reset();
    test_dst_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
